// File: rtl/minus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minus_pkg
// Description : Shared constants and types for the serial subtractor
//               controller: default operand width, FSM state encoding and
//               requester index type.
// Revision    : 1.0 - initial release
// ============================================================================
package minus_pkg;

    // Default operand/result width in bits
    localparam int c_default_width = 16;

    // Controller states: wait for a request, shift bits, hold completion
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index of one of the two requesters
    typedef logic req_idx_t;

endpackage : minus_pkg
`default_nettype wire

// File: rtl/borrow_cell.sv
`default_nettype none
// ============================================================================
// Module      : borrow_cell
// Description : One-bit full subtractor: difference and borrow-out of
//               x - y - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module borrow_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow propagated to the next more significant bit
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~x & bin) | (y & bin);
    end

endmodule : borrow_cell
`default_nettype wire

// File: rtl/serial_minus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_minus_ctrl
// Description : Two-requester four-phase handshake controller around a
//               bit-serial subtractor. One operation computes x - y over
//               WIDTH clock edges, LSB first, through a single borrow cell.
//               Round-robin priority resolves simultaneous requests.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_minus_ctrl
    import minus_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             fin0,
    output logic             fin1,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);

    localparam int c_cw = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    req_idx_t         r_gnt;
    req_idx_t         r_ptr;
    req_idx_t         w_gnt_sel;
    logic             w_any_req;
    logic             w_req_gnt;
    logic             w_last;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_s;
    logic             r_b;
    logic             r_cout;
    logic             r_fin0;
    logic             r_fin1;
    logic [c_cw-1:0]  r_cnt;
    logic             w_d;
    logic             w_bout;

    // Single subtract cell fed by the LSBs of the operand shift registers
    borrow_cell u_cell (
        .x    (r_x[0]),
        .y    (r_y[0]),
        .bin  (r_b),
        .d    (w_d),
        .bout (w_bout)
    );

    // Arbitration, handshake qualifiers and next-state selection
    always_comb begin
        w_state_nxt = r_state;
        w_any_req   = req0 | req1;
        w_req_gnt   = r_gnt ? req1 : req0;
        w_last      = (r_cnt == c_cw'(WIDTH - 1));
        if (req0 && req1) begin
            w_gnt_sel = r_ptr;
        end else begin
            w_gnt_sel = req1;
        end
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    if (!w_req_gnt) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, serial datapath, result load and completion flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt  <= 1'b0;
            r_ptr  <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_res  <= '0;
            r_s    <= '0;
            r_b    <= 1'b0;
            r_cout <= 1'b0;
            r_fin0 <= 1'b0;
            r_fin1 <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt <= w_gnt_sel;
                        r_x   <= w_gnt_sel ? x1 : x0;
                        r_y   <= w_gnt_sel ? y1 : y0;
                        r_b   <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_x   <= r_x >> 1;
                    r_y   <= r_y >> 1;
                    r_b   <= w_bout;
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s    <= {w_d, r_res[WIDTH-1:1]};
                        r_cout <= w_bout;
                        if (r_gnt) begin
                            r_fin1 <= 1'b1;
                        end else begin
                            r_fin0 <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Completion drops with the granted request; the other
                    // requester gets priority on the next contention.
                    if (!w_req_gnt) begin
                        r_fin0 <= 1'b0;
                        r_fin1 <= 1'b0;
                        r_ptr  <= ~r_gnt;
                    end
                end
                default: begin
                    r_fin0 <= 1'b0;
                    r_fin1 <= 1'b0;
                end
            endcase
        end
    end

    assign fin0 = r_fin0;
    assign fin1 = r_fin1;
    assign s    = r_s;
    assign cout = r_cout;
    assign busy = (r_state != IDLE);

endmodule : serial_minus_ctrl
`default_nettype wire

// File: tb/tb_serial_minus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_minus_ctrl
// Description : Directed self-checking bench for serial_minus_ctrl, WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_minus_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             req0;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] y0;
    logic             req1;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    logic             fin0;
    logic             fin1;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;
    logic both_hi = 1'b0;

    serial_minus_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .x0   (x0),
        .y0   (y0),
        .req1 (req1),
        .x1   (x1),
        .y1   (y1),
        .fin0 (fin0),
        .fin1 (fin1),
        .s    (s),
        .cout (cout),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sticky flag if both completions are ever high together
    always @(negedge clk) begin
        if (fin0 && fin1) both_hi = 1'b1;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Count edges (from the current point) until either fin is high, bounded
    task automatic wait_fin(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(fin0 || fin1) && n < 60);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({fin0, fin1, busy, cout} !== 4'b0000 || s !== 16'h0000)
            $display("FAIL reset_state: fin0=%b fin1=%b busy=%b cout=%b s=%h required all 0",
                     fin0, fin1, busy, cout, s);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        logic f1_seen;
        @(negedge clk);
        req0 = 1'b1; x0 = 16'h1234; y0 = 16'h0034;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL basic_grant_busy: busy=%b required 1", busy);
        else n_pass++;
        x0 = 16'hFFFF; y0 = 16'h7777;
        n = 0; f1_seen = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (fin1) f1_seen = 1'b1;
        end while (!fin0 && n < 60);
        n_total++;
        if (n !== 16) $display("FAIL basic_latency: edges=%0d required 16", n);
        else n_pass++;
        n_total++;
        if (s !== 16'h1200 || cout !== 1'b0)
            $display("FAIL basic_result: s=%h cout=%b required s=1200 cout=0", s, cout);
        else n_pass++;
        n_total++;
        if (f1_seen !== 1'b0) $display("FAIL basic_fin1_quiet: fin1 seen=%b required 0", f1_seen);
        else n_pass++;
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (fin0 !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_release: fin0=%b busy=%b required 0 0", fin0, busy);
        else n_pass++;
    endtask

    task automatic test_borrow();
        int n;
        @(negedge clk);
        req0 = 1'b1; x0 = 16'h0000; y0 = 16'h0001;
        wait_fin(n);
        n_total++;
        if (n !== 17 || s !== 16'hFFFF || cout !== 1'b1)
            $display("FAIL borrow_result: edges=%0d s=%h cout=%b required 17 FFFF 1", n, s, cout);
        else n_pass++;
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int n;
        apply_reset();
        req0 = 1'b1; x0 = 16'd5; y0 = 16'd3;
        req1 = 1'b1; x1 = 16'd3; y1 = 16'd5;
        wait_fin(n);
        n_total++;
        if (fin0 !== 1'b1 || fin1 !== 1'b0 || n !== 17)
            $display("FAIL arb_first_grant: fin0=%b fin1=%b edges=%0d required 1 0 17", fin0, fin1, n);
        else n_pass++;
        n_total++;
        if (s !== 16'h0002 || cout !== 1'b0)
            $display("FAIL arb_first_result: s=%h cout=%b required 0002 0", s, cout);
        else n_pass++;
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (fin0 !== 1'b0 || busy !== 1'b0)
            $display("FAIL arb_exit_no_grant: fin0=%b busy=%b required 0 0", fin0, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL arb_second_grant: busy=%b required 1", busy);
        else n_pass++;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!fin1 && n < 60);
        n_total++;
        if (n !== 16 || fin0 !== 1'b0 || s !== 16'hFFFE || cout !== 1'b1)
            $display("FAIL arb_second_result: edges=%0d fin0=%b s=%h cout=%b required 16 0 FFFE 1",
                     n, fin0, s, cout);
        else n_pass++;
        @(negedge clk);
        req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        req0 = 1'b1; x0 = 16'hFFFF; y0 = 16'h0001;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_total++;
        if ({fin0, fin1, busy, cout} !== 4'b0000 || s !== 16'h0000)
            $display("FAIL midreset_clear: fin0=%b fin1=%b busy=%b cout=%b s=%h required all 0",
                     fin0, fin1, busy, cout, s);
        else n_pass++;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; x0 = 16'hAAAA; y0 = 16'h5555;
        wait_fin(n);
        n_total++;
        if (n !== 17 || s !== 16'h5555 || cout !== 1'b0)
            $display("FAIL midreset_rerun: edges=%0d s=%h cout=%b required 17 5555 0", n, s, cout);
        else n_pass++;
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int n;
        int hi;
        @(negedge clk);
        req0 = 1'b1; x0 = 16'hAAAA; y0 = 16'hAAAA;
        wait_fin(n);
        n_total++;
        if (fin0 !== 1'b1 || s !== 16'h0000 || cout !== 1'b0)
            $display("FAIL hold_result: fin0=%b s=%h cout=%b required 1 0000 0", fin0, s, cout);
        else n_pass++;
        hi = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (fin0) hi++;
        end
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (hi !== 6 || fin0 !== 1'b0 || busy !== 1'b0)
            $display("FAIL hold_fin_width: cycles=%0d fin0=%b busy=%b required 6 0 0", hi, fin0, busy);
        else n_pass++;
    endtask

    task automatic test_drop_in_shift();
        int n;
        @(negedge clk);
        req1 = 1'b1; x1 = 16'h0010; y1 = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        n = 1;
        while (!fin1 && n < 60) begin
            @(posedge clk); #1;
            if (!fin1) n++;
        end
        n_total++;
        if (fin1 !== 1'b1 || s !== 16'h000F || cout !== 1'b0)
            $display("FAIL drop_result: fin1=%b s=%h cout=%b required 1 000F 0", fin1, s, cout);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (fin1 !== 1'b0 || busy !== 1'b0)
            $display("FAIL drop_one_cycle: fin1=%b busy=%b required 0 0", fin1, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic g;
        apply_reset();
        req0 = 1'b1; x0 = 16'd9; y0 = 16'd1;
        req1 = 1'b1; x1 = 16'd1; y1 = 16'd9;
        for (int op = 0; op < 4; op++) begin
            wait_fin(n);
            g = fin1;
            n_total++;
            if (g !== op[0] || n !== 17 || s !== (g ? 16'hFFF8 : 16'h0008))
                $display("FAIL b2b_op%0d: grant=%b edges=%0d s=%h required %0d 17 %h",
                         op, g, n, s, op[0], (op[0] ? 16'hFFF8 : 16'h0008));
            else n_pass++;
            @(negedge clk);
            if (g) req1 = 1'b0; else req0 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (g) req1 = 1'b1; else req0 = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_exclusive();
        n_total++;
        if (both_hi !== 1'b0) $display("FAIL fin_exclusive: both high seen=%b required 0", both_hi);
        else n_pass++;
    endtask

    initial begin
        rst  = 1'b1;
        req0 = 1'b0; x0 = '0; y0 = '0;
        req1 = 1'b0; x1 = '0; y1 = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_arbitration();
        test_reset_mid();
        test_hold();
        test_drop_in_shift();
        test_back_to_back();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_minus_ctrl
`default_nettype wire

// File: doc/serial_minus_ctrl.md
SERIAL_MINUS_CTRL -- requirements
Module: serial_minus_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal values 2..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port req0, input, 1, the requester 0 four-phase request.
REQ-005 The block SHALL have port x0, input, WIDTH, the requester 0 minuend.
REQ-006 The block SHALL have port y0, input, WIDTH, the requester 0 subtrahend.
REQ-007 The block SHALL have ports req1, x1 and y1, with the same directions and widths as req0, x0 and y0, for requester 1.
REQ-008 The block SHALL have port fin0, output, 1, the requester 0 completion, registered.
REQ-009 The block SHALL have port fin1, output, 1, the requester 1 completion, registered.
REQ-010 The block SHALL have port s, output, WIDTH, the difference x-y mod 2^WIDTH of the last completed operation.
REQ-011 The block SHALL have port cout, output, 1, the final borrow of the last completed operation (1 iff x<y unsigned).
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-014 In IDLE with at least one req high, the block SHALL grant one requester, capture its x/y into shift registers, clear the borrow register and the bit counter, and enter SHIFT on that edge (the grant edge).
REQ-015 With both req high in IDLE, the grant SHALL go to the priority pointer; the pointer resets to 0 and points to the non-served requester after each DONE exit.
REQ-016 In SHIFT, the block SHALL process one bit per edge, LSB first, through a single one-bit subtract cell: d = x^y^b and b' = (~x&y)|(~x&b)|(y&b), with d shifted into the result register MSB-first so that the result is LSB-aligned after WIDTH edges.
REQ-017 On the WIDTH-th edge after the grant edge, the block SHALL load s and cout, set fin of the granted requester to 1, and enter DONE.
REQ-018 fin SHALL rise exactly WIDTH rising edges after the grant edge, which is WIDTH+1 edges from the first IDLE edge at which req is sampled high.
REQ-019 In DONE, fin SHALL stay high while the granted req is high; on the first edge sampling it low, fin SHALL fall and the FSM SHALL return to IDLE.
REQ-020 No new grant SHALL occur on the DONE-exit edge.
REQ-021 A granted req that drops during SHIFT SHALL NOT abort the operation; the operation completes, and fin is high for exactly one cycle.
REQ-022 Operand changes after the grant edge SHALL have no effect on the result.
REQ-023 The non-granted requester SHALL see its fin held at 0 and its request remain pending.
REQ-024 s and cout SHALL hold their value between completions and SHALL change only on the edge that enters DONE.
REQ-025 fin0 and fin1 SHALL never be high simultaneously.

Reset
REQ-026 While rst is high, the block SHALL immediately force state=IDLE, fin0=fin1=0, busy=0, s=0, cout=0, priority pointer=0, and clear the counter, borrow and shift registers.
REQ-027 A reset asserted mid-SHIFT or mid-DONE SHALL discard the operation, and the first edge after release SHALL behave as a fresh IDLE.

Structure
REQ-028 Package minus_pkg SHALL hold the default WIDTH constant, the FSM state typedef (IDLE/SHIFT/DONE), and the requester-index typedef.
REQ-029 The one-bit subtract logic SHALL be a combinational sub-module named borrow_cell (inputs x, y, bin; outputs d, bout), instantiated once.
REQ-030 The FSM, arbiter, counter and shift registers SHALL be in serial_minus_ctrl.

Verification (WIDTH=16)
REQ-031 The bench SHALL drive req0 with x0=0x1234 and y0=0x0034 and require fin0 to rise 16 edges after the grant, with s=0x1200, cout=0 and fin1=0 throughout.
REQ-032 The bench SHALL drive x0=0x0000 and y0=0x0001 and require s=0xFFFF and cout=1.
REQ-033 The bench SHALL assert, on the same edge after reset, req0 (5-3) and req1 (3-5), and require req0 served first with s=0x0002 and cout=0; after req0 drops and fin0 falls, require req1 granted on the next IDLE edge with s=0xFFFE and cout=1.
REQ-034 The bench SHALL assert rst on the 8th SHIFT edge and require fin0, fin1, busy, s and cout to be 0 before the next clk edge; a re-request of 0xAAAA-0x5555 SHALL then give s=0x5555 and cout=0.
REQ-035 The bench SHALL drive x=y=0xAAAA with req held 5 cycles past fin, and require s=0x0000, cout=0, fin high for 6 cycles and falling on the edge that samples req low.
REQ-036 The bench SHALL re-request req0 immediately while req1 is pending, and require grants to alternate 0,1,0,1 over four operations.
